riscv_dmem_ctrl: RTL and testbench

Parametrised data-memory controller that replaces the fixed single-cycle data memory behind the core's load/store port. It accepts byte, halfword and word requests over a valid/ready handshake, inserts a configurable number of wait states, and returns sign- or zero-extended load data with an error flag. It sits between `riscv_core` and on-chip SRAM storage inside `riscv_wrapper`.

---
 rtl/riscv_dmem_pkg.sv | 40 ++++
 rtl/riscv_dmem_lane.sv | 26 ++
 rtl/riscv_dmem_ctrl.sv | 149 ++++++++++++++
 tb/tb_riscv_dmem_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dmem_pkg.sv
// rtl/riscv_dmem_pkg.sv - shared types and lane helpers for the data-memory controller
package riscv_dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_ILL = 2'd3
    } dmem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Byte lanes touched by an access of the given size at the given (aligned) offset
    function automatic logic [3:0] lane_mask(input dmem_size_e size, input logic [1:0] off);
        case (size)
            SZ_B:    lane_mask = 4'b0001 << off;
            SZ_H:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Shift the addressed lanes down to bit 0 and sign- or zero-extend
    function automatic logic [31:0] extend_load(input logic [31:0] word, input dmem_size_e size,
                                                input logic [1:0] off, input logic is_unsigned);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_B:    extend_load = is_unsigned ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    extend_load = is_unsigned ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            SZ_W:    extend_load = word;
            default: extend_load = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_dmem_lane.sv
// rtl/riscv_dmem_lane.sv - byte-enable, store replication and load extraction unit
module riscv_dmem_lane
    import riscv_dmem_pkg::*;
(
    input  dmem_size_e  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata
);

    // Right-aligned store data is replicated so every lane carries it; byte_en picks the real ones
    always_comb begin
        byte_en = lane_mask(size, offset);
        case (size)
            SZ_B:    wdata_rep = {4{wdata[7:0]}};
            SZ_H:    wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
        rdata = extend_load(rword, size, offset, is_unsigned);
    end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// rtl/riscv_dmem_ctrl.sv - wait-state data-memory controller; RISCV_DMEM_MISALIGN_TRAP_EN traps misaligned accesses
module riscv_dmem_ctrl
    import riscv_dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    dmem_state_e state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic        lat_uns;
    dmem_size_e  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] off;
    logic        range_err;
    logic        size_err;
    logic        align_err;
    logic        acc_err;
    logic [1:0]  lane_off;
    logic [AW-1:0] word_idx;
    logic        commit;

    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;
    logic [31:0] load_data;
    logic [31:0] rword;

    logic [31:0] mem [DEPTH_WORDS];

    // Fault decode and effective lane offset for the latched request
    always_comb begin
        off       = lat_addr - BASE_ADDR;
        range_err = {1'b0, off} >= SPAN;
        size_err  = (lat_size == SZ_ILL);
`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
        align_err = ((lat_size == SZ_H) && lat_addr[0]) ||
                    ((lat_size == SZ_W) && (lat_addr[1:0] != 2'b00));
        lane_off  = lat_addr[1:0];
`else
        align_err = 1'b0;
        case (lat_size)
            SZ_W:    lane_off = 2'b00;
            SZ_H:    lane_off = {lat_addr[1], 1'b0};
            default: lane_off = lat_addr[1:0];
        endcase
`endif
        acc_err  = range_err | size_err | align_err;
        word_idx = off[AW+1:2];
        commit   = (state == WAIT) && (cnt == 4'd0);
        rword    = mem[word_idx];
    end

    riscv_dmem_lane u_lane (
        .size        (lat_size),
        .offset      (lane_off),
        .is_unsigned (lat_uns),
        .wdata       (lat_wdata),
        .rword       (rword),
        .byte_en     (byte_en),
        .wdata_rep   (wdata_rep),
        .rdata       (load_data)
    );

    // Storage: per-byte writes on the commit edge; contents survive reset
    always_ff @(posedge clk) begin
        if (commit && lat_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    // Control FSM; the counter is loaded with WAIT_STATES so the commit edge lands
    // WAIT_STATES+1 edges after acceptance, which is also when rsp_valid rises
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= SZ_B;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_we    <= req_we;
                        lat_uns   <= req_unsigned;
                        lat_size  <= dmem_size_e'(req_size);
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cnt       <= 4'(WAIT_STATES);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || lat_we) ? 32'h0 : load_data;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// tb/tb_riscv_dmem_ctrl.sv - randomized self-checking bench with a byte-array reference model
module tb_riscv_dmem_ctrl;

    localparam int          DW   = 64;
    localparam int          WS   = 2;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    riscv_dmem_ctrl #(.DEPTH_WORDS(DW), .WAIT_STATES(WS), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference storage: flat byte array indexed by offset from BASE
    logic [7:0] mbytes [4*DW];

    function automatic void model_access(input logic we, input logic [1:0] size, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] wdata,
                                         output logic err, output logic [31:0] rdata);
        logic [31:0] off;
        int nb;
        int a;
        off   = addr - BASE;
        err   = 1'b0;
        rdata = 32'h0;
        if (off >= 32'(4*DW) || size == 2'd3) begin
            err = 1'b1;
            return;
        end
        nb = 1 << size;
`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
        if ((int'(addr) % nb) != 0) begin
            err = 1'b1;
            return;
        end
`endif
        a = (int'(off) / nb) * nb;
        if (we) begin
            for (int i = 0; i < nb; i++) mbytes[a+i] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++) rdata[8*i +: 8] = mbytes[a+i];
            if (!uns && nb < 4 && rdata[8*nb-1]) rdata = rdata | ~((32'h1 << (8*nb)) - 32'h1);
        end
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction currently in flight, as seen by the compare process
    logic        pend = 1'b0;
    logic        seen = 1'b0;
    int          acc_cyc = 0;
    logic        p_we, p_uns;
    logic [1:0]  p_size;
    logic [31:0] p_addr, p_wdata;
    logic [31:0] got_rdata, exp_rdata;
    logic        got_err, exp_err;

    // Compare process: latency, response contents against the model, and stability while held
    always @(negedge clk) begin
        if (pend && reset) begin
            check("req_ready_busy", 32'(req_ready), 32'd0);
            if (rsp_valid && !seen) begin
                seen = 1'b1;
                check("latency", 32'(cyc - acc_cyc), 32'(WS + 1));
                model_access(p_we, p_size, p_uns, p_addr, p_wdata, exp_err, exp_rdata);
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
                check("rsp_rdata", rsp_rdata, exp_rdata);
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
            end else if (rsp_valid) begin
                check("hold_rdata", rsp_rdata, got_rdata);
                check("hold_err", 32'(rsp_err), 32'(got_err));
            end else if (seen) begin
                check("rsp_valid_dropped", 32'(rsp_valid), 32'd1);
            end
        end
    end

    task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                          output logic [31:0] rd, output logic er);
        int t;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        t = 0;
        while (!req_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            rd = 32'h0; er = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        p_we = we; p_size = sz; p_uns = uns; p_addr = addr; p_wdata = wdata;
        acc_cyc = cyc;
        seen = 1'b0;
        pend = 1'b1;
        t = 0;
        while (!seen && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!seen) begin
            check("rsp_timeout", 32'(seen), 32'd1);
            pend = 1'b0; rsp_ready = 1'b1;
            rd = 32'h0; er = 1'b0;
            return;
        end
        if (hold > 0) begin
            // Offer a competing request while the response is stalled
            req_we = 1'b0; req_size = 2'd2; req_addr = BASE; req_valid = 1'b1;
            repeat (hold) @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            pend = 1'b0;
            @(negedge clk);
            check("no_early_accept", 32'(req_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
            pend = 1'b0;
        end
        rd = got_rdata;
        er = got_err;
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        for (int i = 0; i < 4*DW; i++) mbytes[i] = 8'h00;
        #3 reset = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int w = 0; w < DW; w++) access(1'b1, 2'd2, 1'b0, BASE + 32'(4*w), 32'h0, 0, rd, er);

        access(1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEAD_BEEF, 0, rd, er);
        access(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0, rd, er);
        check("lit_word", rd, 32'hDEAD_BEEF);
        check("lit_word_err", 32'(er), 32'd0);
        access(1'b1, 2'd0, 1'b0, 32'h1001, 32'h0000_0080, 0, rd, er);
        access(1'b0, 2'd0, 1'b0, 32'h1001, 32'h0, 0, rd, er);
        check("lit_lb", rd, 32'hFFFF_FF80);
        access(1'b0, 2'd0, 1'b1, 32'h1001, 32'h0, 0, rd, er);
        check("lit_lbu", rd, 32'h0000_0080);
        access(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0, rd, er);
        check("lit_merged", rd, 32'hDEAD_80EF);
        access(1'b0, 2'd2, 1'b0, BASE + 32'(4*DW), 32'h0, 0, rd, er);
        check("lit_range_err", 32'(er), 32'd1);
        check("lit_range_data", rd, 32'h0);
        access(1'b0, 2'd3, 1'b0, 32'h1000, 32'h0, 0, rd, er);
        check("lit_size_err", 32'(er), 32'd1);
        access(1'b1, 2'd1, 1'b0, 32'h1003, 32'h0000_1234, 0, rd, er);
        access(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 5, rd, er);
`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
        check("lit_misalign_word", rd, 32'hDEAD_80EF);
`else
        check("lit_misalign_word", rd, 32'h1234_80EF);
`endif

        // Reset while a store to 0x1008 waits; it must not land
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_addr = 32'h1008; req_wdata = 32'hCAFE_F00D;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_rdata", rsp_rdata, 32'h0);
        check("abort_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        access(1'b0, 2'd2, 1'b0, 32'h1008, 32'h0, 0, rd, er);
        check("lit_abort_load", rd, 32'h0);

        for (int n = 0; n < 300; n++) begin
            int          r;
            logic [1:0]  sz;
            logic [31:0] a;
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 15) == 0) a = BASE - 32'($urandom_range(1, 8));
            else a = BASE + 32'($urandom_range(0, 4*DW + 7));
            access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   int'($urandom_range(0, 2)), rd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
